// File: rtl/theta_slice_if.sv
// rtl/theta_slice_if.sv - slice stream handshake bundle between theta_slice and its neighbours
interface theta_slice_if;
    logic [24:0] in_slice;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] out_slice;
    logic [5:0]  out_z;
    logic        out_valid;
    logic        out_ready;
    logic        round_done;

    modport master (
        output in_slice, in_valid, out_ready,
        input  in_ready, out_slice, out_z, out_valid, round_done
    );

    modport slave (
        input  in_slice, in_valid, out_ready,
        output in_ready, out_slice, out_z, out_valid, round_done
    );
endinterface

// File: rtl/theta_slice.sv
// rtl/theta_slice.sv - slice-serial Keccak-f[1600] theta stage; THETA_BYPASS_EN adds theta_bypass
module theta_slice (
    input  logic         clk,
    input  logic         rst,
`ifdef THETA_BYPASS_EN
    input  logic         theta_bypass,
`endif
    theta_slice_if.slave s
);
    typedef enum logic {LOAD, EMIT} state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  load_cnt;
    logic [5:0]  emit_cnt;
    logic [5:0]  prev_z;
    logic [24:0] slice_buf [64];
    logic [4:0]  par_mem [64];
    logic [4:0]  in_par;
    logic [4:0]  par_cur;
    logic [4:0]  par_prev;
    logic [24:0] cur_slice;
    logic [24:0] theta;
    logic        in_ready_c;
    logic        out_valid_c;
    logic        round_done_c;
    logic        in_fire;
    logic        out_fire;

    assign in_fire  = s.in_valid & in_ready_c;
    assign out_fire = out_valid_c & s.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (in_fire && load_cnt == 6'd63) next_state = EMIT;
            EMIT:    if (out_fire && emit_cnt == 6'd63) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        in_ready_c   = (state == LOAD);
        out_valid_c  = (state == EMIT);
        round_done_c = out_valid_c & s.out_ready & (emit_cnt == 6'd63);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt <= 6'd0;
            emit_cnt <= 6'd0;
        end else begin
            if (in_fire)  load_cnt <= load_cnt + 6'd1;
            if (out_fire) emit_cnt <= emit_cnt + 6'd1;
        end
    end

    // Slice storage is deliberately unreset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            slice_buf[load_cnt] <= s.in_slice;
            par_mem[load_cnt]   <= in_par;
        end
    end

    genvar gx, gy;
    generate
        for (gx = 0; gx < 5; gx++) begin : g_par
            assign in_par[gx] = s.in_slice[gx] ^ s.in_slice[gx + 5] ^ s.in_slice[gx + 10]
                              ^ s.in_slice[gx + 15] ^ s.in_slice[gx + 20];
        end
    endgenerate

    assign prev_z    = emit_cnt - 6'd1;
    assign cur_slice = slice_buf[emit_cnt];
    assign par_cur   = par_mem[emit_cnt];
    assign par_prev  = par_mem[prev_z];

    // Column x mixes parity of x-1 in this slice and x+1 in the previous slice.
    generate
        for (gx = 0; gx < 5; gx++) begin : g_tx
            for (gy = 0; gy < 5; gy++) begin : g_ty
                assign theta[gx + 5 * gy] = cur_slice[gx + 5 * gy]
                                          ^ par_cur[(gx + 4) % 5]
                                          ^ par_prev[(gx + 1) % 5];
            end
        end
    endgenerate

`ifdef THETA_BYPASS_EN
    assign s.out_slice = theta_bypass ? cur_slice : theta;
`else
    assign s.out_slice = theta;
`endif

    assign s.in_ready   = in_ready_c;
    assign s.out_valid  = out_valid_c;
    assign s.out_z      = emit_cnt;
    assign s.round_done = round_done_c;
endmodule

// File: tb/tb_theta_slice.sv
// tb/tb_theta_slice.sv - self-checking bench for theta_slice against a 3-D Keccak theta model
module tb_theta_slice;
    typedef logic [24:0] st_t [64];

    typedef struct {
        string       name;
        int          src_z;
        logic [24:0] src;
        int          a_z;
        logic [24:0] a_exp;
        int          b_z;
        logic [24:0] b_exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic bypass = 1'b0;
    int   errors = 0;
    int   checks = 0;

    theta_slice_if bus ();

    theta_slice dut (
        .clk          (clk),
        .rst          (rst),
`ifdef THETA_BYPASS_EN
        .theta_bypass (bypass),
`endif
        .s            (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic st_t theta_model(input st_t s, input bit byp);
        bit   a [5][5][64];
        bit   c [5][64];
        st_t  o;
        for (int z = 0; z < 64; z++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    a[x][y][z] = s[z][x + 5 * y];
        for (int x = 0; x < 5; x++)
            for (int z = 0; z < 64; z++)
                c[x][z] = a[x][0][z] ^ a[x][1][z] ^ a[x][2][z] ^ a[x][3][z] ^ a[x][4][z];
        for (int z = 0; z < 64; z++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    o[z][x + 5 * y] = byp ? a[x][y][z]
                                    : a[x][y][z] ^ c[(x + 4) % 5][z] ^ c[(x + 1) % 5][(z + 63) % 64];
        return o;
    endfunction

    // Loads a full state, then drains it, checking every output cycle against the model.
    task automatic do_round(input st_t s, input int stall_z, input int stall_len,
                            input bit gaps, output st_t got);
        st_t exp;
        int  z;
        int  guard;
        int  stalled;
        bit  stall;
        bit  ov_seen;
        exp = theta_model(s, bypass);
        z = 0; guard = 0; ov_seen = 0;
        while (z < 64 && guard < 1000) begin
            guard++;
            bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_slice = s[z];
            #1;
            if (bus.out_valid) ov_seen = 1;
            if (bus.in_valid && bus.in_ready) z++;
            @(posedge clk); #1;
        end
        chk("load_done", z, 64);
        chk("no_out_valid_during_load", ov_seen, 0);
        bus.in_valid = gaps;
        bus.in_slice = $urandom;
        chk("first_out_valid", bus.out_valid, 1);
        chk("in_ready_low_emit", bus.in_ready, 0);
        z = 0; guard = 0; stalled = 0;
        while (z < 64 && guard < 2000) begin
            guard++;
            stall = (z == stall_z && stalled < stall_len);
            bus.out_ready = !stall;
            #1;
            chk("out_valid", bus.out_valid, 1);
            chk("out_z", bus.out_z, z);
            chk($sformatf("out_slice_z%0d", z), bus.out_slice, exp[z]);
            chk("round_done", bus.round_done, (!stall && z == 63));
            got[z] = bus.out_slice;
            if (stall) stalled++;
            else z++;
            @(posedge clk); #1;
        end
        chk("emit_done", z, 64);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        #1;
        chk("back_to_load_in_ready", bus.in_ready, 1);
        chk("back_to_load_out_valid", bus.out_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_z", bus.out_z, 0);
        chk("rst_round_done", bus.round_done, 0);
    endtask

    vec_t vecs [3];
    st_t  st;
    st_t  got;
    st_t  ref_got;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_slice  = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_reset();

        vecs[0] = '{"all_zero",   0,  25'h0, 0,  25'h0,       63, 25'h0};
        vecs[1] = '{"single_z0",  0,  25'h1, 0,  25'h0210843, 1,  25'h1084210};
        vecs[2] = '{"wrap_z63",   63, 25'h1, 63, 25'h0210843, 0,  25'h1084210};
        for (int i = 0; i < 3; i++) begin
            foreach (st[z]) st[z] = '0;
            st[vecs[i].src_z] = vecs[i].src;
            do_round(st, -1, 0, 0, got);
            chk({vecs[i].name, "_a"}, got[vecs[i].a_z], vecs[i].a_exp);
            chk({vecs[i].name, "_b"}, got[vecs[i].b_z], vecs[i].b_exp);
        end

        // Backpressure: five stall cycles while presenting z=20.
        foreach (st[z]) st[z] = 25'($urandom);
        do_round(st, 20, 5, 0, got);

        // Randomized rounds with input gaps, in_valid held during emit, and random stalls.
        for (int r = 0; r < 4; r++) begin
            foreach (st[z]) st[z] = 25'($urandom);
            do_round(st, $urandom_range(0, 63), $urandom_range(0, 4), 1, got);
        end

        // Reset partway through a load discards those slices.
        foreach (st[z]) st[z] = '0;
        st[0] = 25'h1;
        for (int z = 0; z < 10; z++) begin
            bus.in_valid = 1'b1;
            bus.in_slice = 25'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        do_reset();
        do_round(st, -1, 0, 0, got);
        chk("post_reset_z0", got[0], 25'h0210843);
        chk("post_reset_z1", got[1], 25'h1084210);
        chk("post_reset_z2", got[2], 25'h0);

`ifdef THETA_BYPASS_EN
        bypass = 1'b1;
        do_round(st, -1, 0, 0, got);
        chk("bypass_z0", got[0], 25'h1);
        chk("bypass_z1", got[1], 25'h0);
        bypass = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
